// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave feeding the SDRAM controller's write/read FIFOs and stream enables.
// Write ack 1 cycle after strobe, read ack 2 (plus 1 at stream start); stalls on wr_fifo_full, read times out after TIMEOUT.
module wb_sdram_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_int_o,
  input  logic        sdram_ready,
  output logic        write_en,
  output logic        read_en,
  output logic [21:0] address,
  output logic        wr_fifo_wr,
  output logic [31:0] wr_fifo_data,
  output logic [3:0]  wr_fifo_mask,
  input  logic        wr_fifo_full,
  output logic        rd_fifo_rd,
  input  logic [31:0] rd_fifo_data,
  input  logic        rd_fifo_empty,
  output logic        rd_fifo_reset
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, READ_POP, FLUSH, GUARD} state_t;

  state_t        state;
  logic [31:0]   next_adr;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   dat_q;
  logic          pop_ack;
  logic          strobe;

  // A strobe seen while our ack/err is still high is the one just terminated.
  assign strobe = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;

  // FIFO data is only valid in the ack cycle, so pass it through then and hold it afterwards.
  assign wbs_dat_o = pop_ack ? rd_fifo_data : dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      next_adr      <= '0;
      tmo_cnt       <= '0;
      dat_q         <= '0;
      pop_ack       <= 1'b0;
      wbs_ack_o     <= 1'b0;
      wbs_err_o     <= 1'b0;
      wbs_int_o     <= 1'b0;
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      address       <= '0;
      wr_fifo_wr    <= 1'b0;
      wr_fifo_data  <= '0;
      wr_fifo_mask  <= '0;
      rd_fifo_rd    <= 1'b0;
      rd_fifo_reset <= 1'b0;
    end else begin
      wbs_ack_o     <= 1'b0;
      wbs_err_o     <= 1'b0;
      wr_fifo_wr    <= 1'b0;
      rd_fifo_rd    <= 1'b0;
      rd_fifo_reset <= 1'b0;
      pop_ack       <= 1'b0;
      if (pop_ack) dat_q <= rd_fifo_data;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (strobe && sdram_ready) begin
            address  <= {wbs_adr_i[20:0], 1'b0};
            next_adr <= wbs_adr_i;
            write_en <= wbs_we_i;
            read_en  <= ~wbs_we_i;
            state    <= wbs_we_i ? WRITE : READ_WAIT;
          end
        end

        WRITE: begin
          if (!wbs_cyc_i) begin
            write_en <= 1'b0;
            state    <= GUARD;
          end else if (strobe) begin
            if (!wbs_we_i || wbs_adr_i != next_adr) begin
              wbs_err_o <= 1'b1;
            end else if (!wr_fifo_full) begin
              wr_fifo_wr   <= 1'b1;
              wr_fifo_data <= wbs_dat_i;
              wr_fifo_mask <= ~wbs_sel_i;
              wbs_ack_o    <= 1'b1;
              next_adr     <= next_adr + 32'd1;
            end
          end
        end

        READ_WAIT: begin
          if (!wbs_cyc_i) begin
            read_en       <= 1'b0;
            rd_fifo_reset <= 1'b1;
            state         <= FLUSH;
          end else if (strobe) begin
            if (wbs_we_i) begin
              wbs_err_o <= 1'b1;
            end else if (wbs_adr_i != next_adr) begin
              // Prefetched data belongs to the old stream; restart from IDLE.
              read_en       <= 1'b0;
              rd_fifo_reset <= 1'b1;
              state         <= FLUSH;
            end else if (!rd_fifo_empty) begin
              rd_fifo_rd <= 1'b1;
              state      <= READ_POP;
            end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
              wbs_ack_o     <= 1'b1;
              dat_q         <= '0;
              wbs_int_o     <= 1'b1;
              read_en       <= 1'b0;
              rd_fifo_reset <= 1'b1;
              state         <= FLUSH;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        READ_POP: begin
          pop_ack   <= 1'b1;
          wbs_ack_o <= 1'b1;
          next_adr  <= next_adr + 32'd1;
          tmo_cnt   <= '0;
          state     <= READ_WAIT;
        end

        FLUSH: state <= GUARD;

        GUARD: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Scoreboarded bench: Wishbone master tasks, read-FIFO model, and push/ack monitors.
module tb_wb_sdram_bridge;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_int_o;
  logic        sdram_ready, write_en, read_en;
  logic [21:0] address;
  logic        wr_fifo_wr;
  logic [31:0] wr_fifo_data;
  logic [3:0]  wr_fifo_mask;
  logic        wr_fifo_full;
  logic        rd_fifo_rd;
  logic [31:0] rd_fifo_data = '0;
  logic        rd_fifo_empty;
  logic        rd_fifo_reset;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [35:0] wr_exp[$];
  logic [31:0] rd_exp[$];
  logic        cur_we = 1'b0;
  int          wr_pushes = 0;

  logic [31:0] feed_mem [0:63];
  int          feed_wr = 0;
  int          feed_rd = 0;
  logic        hold_empty = 1'b0;

  wb_sdram_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_int_o(wbs_int_o),
    .sdram_ready(sdram_ready), .write_en(write_en), .read_en(read_en), .address(address),
    .wr_fifo_wr(wr_fifo_wr), .wr_fifo_data(wr_fifo_data), .wr_fifo_mask(wr_fifo_mask),
    .wr_fifo_full(wr_fifo_full), .rd_fifo_rd(rd_fifo_rd), .rd_fifo_data(rd_fifo_data),
    .rd_fifo_empty(rd_fifo_empty), .rd_fifo_reset(rd_fifo_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Read FIFO: data registered on the pop edge, flushed by rd_fifo_reset.
  assign rd_fifo_empty = hold_empty || (feed_rd == feed_wr);
  always @(posedge clk) begin
    if (rd_fifo_reset) feed_rd <= feed_wr;
    else if (rd_fifo_rd && !rd_fifo_empty) begin
      rd_fifo_data <= feed_mem[feed_rd[5:0]];
      feed_rd      <= feed_rd + 1;
    end
  end

  task automatic feed(input logic [31:0] d);
    feed_mem[feed_wr[5:0]] = d;
    feed_wr++;
  endtask

  always @(negedge clk) begin
    logic [35:0] we_e;
    logic [31:0] rd_e;
    if (rst_n && wr_fifo_wr) begin
      wr_pushes++;
      if (wr_exp.size() == 0) chk("wr_unexpected_push", 32'(wr_exp.size()), 32'd1);
      else begin
        we_e = wr_exp.pop_front();
        chk("wr_data", wr_fifo_data, we_e[35:4]);
        chk("wr_mask", {28'd0, wr_fifo_mask}, {28'd0, we_e[3:0]});
      end
    end
    if (rst_n && wbs_ack_o && !cur_we) begin
      if (rd_exp.size() == 0) chk("rd_unexpected_ack", 32'(rd_exp.size()), 32'd1);
      else begin
        rd_e = rd_exp.pop_front();
        chk("rd_data", wbs_dat_o, rd_e);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic push, input logic [31:0] rexp);
    cur_we    = w;
    wbs_adr_i = a;
    wbs_we_i  = w;
    wbs_dat_i = d;
    wbs_sel_i = s;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    if (push) begin
      if (w) wr_exp.push_back({d, ~s});
      else   rd_exp.push_back(rexp);
    end
  endtask

  // lat counts negedges from the drive point up to the terminating cycle.
  task automatic wait_term(output int lat, output logic got_err);
    logic done;
    done    = 1'b0;
    lat     = 0;
    got_err = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (wbs_ack_o || wbs_err_o) begin
        done    = 1'b1;
        got_err = wbs_err_o;
      end
    end
    chk("xfer_terminated", 32'(done), 32'd1);
    @(posedge clk);
    #1 wbs_stb_i = 1'b0;
  endtask

  task automatic end_cyc();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          p0;
    int          idx;
    int          pulses;
    logic        e;
    logic        seen;
    logic [3:0]  bs;

    rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    sdram_ready = 1'b0; wr_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {20'd0, write_en, read_en, wr_fifo_wr, rd_fifo_rd, rd_fifo_reset,
                    wbs_ack_o, wbs_err_o, wbs_int_o, wr_fifo_mask}, 32'd0);
    chk("rst_dat_o", wbs_dat_o, 32'd0);
    chk("rst_address", {10'd0, address}, 32'd0);
    chk("rst_wr_data", wr_fifo_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Not ready: strobe must sit unanswered, then a single write goes through.
    drive(32'h10, 1'b1, 32'hA5A5_0001, 4'hF, 1'b1, 32'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (wbs_ack_o || write_en) pulses++;
    end
    chk("not_ready_quiet", 32'(pulses), 32'd0);
    @(posedge clk); #1 sdram_ready = 1'b1;
    wait_term(lat, e);
    chk("first_wr_err", 32'(e), 32'd0);
    chk("first_wr_lat", 32'(lat), 32'd3);
    chk("first_wr_address", {10'd0, address}, 32'h20);
    end_cyc();
    @(negedge clk); chk("wr_end_en_hold", 32'(write_en), 32'd1);
    @(negedge clk); chk("wr_end_en_drop", 32'(write_en), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Burst with a byte-select hole and a 5-cycle full stall before word 2.
    p0 = wr_pushes;
    for (int i = 0; i < 4; i++) begin
      bs = (i == 2) ? 4'h3 : 4'hF;
      if (i == 1) begin
        wr_fifo_full = 1'b1;
        fork
          begin repeat (5) @(posedge clk); #1 wr_fifo_full = 1'b0; end
        join_none
      end
      drive(32'h100 + i, 1'b1, 32'hB0B0_0000 + i, bs, 1'b1, 32'd0);
      wait_term(lat, e);
      if (i == 0) chk("burst_first_lat", 32'(lat), 32'd3);
      if (i == 1) chk("full_stall_lat", 32'(lat), 32'd7);
      if (i == 3) chk("burst_lat", 32'(lat), 32'd2);
    end
    end_cyc();
    repeat (3) @(posedge clk); #1;
    chk("burst_pushes", 32'(wr_pushes - p0), 32'd4);

    // Read burst, then one flush pulse coinciding with read_en falling.
    for (int i = 0; i < 4; i++) feed(32'h1111_0000 + i);
    for (int i = 0; i < 4; i++) begin
      drive(32'h40 + i, 1'b0, 32'd0, 4'hF, 1'b1, 32'h1111_0000 + i);
      wait_term(lat, e);
      if (i == 0) chk("rd_first_lat", 32'(lat), 32'd4);
      if (i == 1) chk("rd_lat", 32'(lat), 32'd3);
    end
    end_cyc();
    idx = 0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rd_fifo_reset) begin
        pulses++;
        idx = k;
        chk("flush_read_en_low", 32'(read_en), 32'd0);
      end
    end
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("flush_cycle", 32'(idx), 32'd2);
    @(posedge clk); #1;

    // Address jump mid-stream: stale prefetch dropped, stream restarts at 0x80.
    feed(32'h2222_0000);
    feed(32'h2222_0001);
    drive(32'h40, 1'b0, 32'd0, 4'hF, 1'b1, 32'h2222_0000);
    wait_term(lat, e);
    seen = 1'b0;
    drive(32'h80, 1'b0, 32'd0, 4'hF, 1'b1, 32'h3333_0000);
    fork
      begin
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          if (rd_fifo_reset) seen = 1'b1;
        end
        @(posedge clk); #1 feed(32'h3333_0000);
      end
      wait_term(lat, e);
    join
    chk("jump_flush", 32'(seen), 32'd1);
    chk("restart_address", {10'd0, address}, 32'h100);
    end_cyc();
    repeat (6) @(posedge clk); #1;

    // Empty FIFO: timeout ack with zero data and a sticky interrupt.
    hold_empty = 1'b1;
    drive(32'h200, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0);
    wait_term(lat, e);
    chk("timeout_lat", 32'(lat), 32'(TO + 2));
    chk("timeout_int", 32'(wbs_int_o), 32'd1);
    end_cyc();
    hold_empty = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); chk("int_sticky", 32'(wbs_int_o), 32'd1);
    @(posedge clk); #1;

    // Non-sequential write errors without a push; then reset mid-burst.
    p0 = wr_pushes;
    drive(32'h300, 1'b1, 32'hC0C0_0000, 4'hF, 1'b1, 32'd0);
    wait_term(lat, e);
    chk("seq_first_err", 32'(e), 32'd0);
    drive(32'h305, 1'b1, 32'hC0C0_0005, 4'hF, 1'b0, 32'd0);
    wait_term(lat, e);
    chk("seq_err", 32'(e), 32'd1);
    chk("seq_err_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("err_one_cycle", 32'(wbs_err_o), 32'd0);
    chk("err_no_push", 32'(wr_pushes - p0), 32'd1);
    @(posedge clk); #1;
    drive(32'h301, 1'b1, 32'hC0C0_0001, 4'hF, 1'b0, 32'd0);
    @(negedge clk); chk("pre_rst_write_en", 32'(write_en), 32'd1);
    @(posedge clk); #1;
    chk("pre_rst_ack", 32'(wbs_ack_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {20'd0, write_en, read_en, wr_fifo_wr, rd_fifo_rd, rd_fifo_reset,
                        wbs_ack_o, wbs_err_o, wbs_int_o, wr_fifo_mask}, 32'd0);
    chk("mid_rst_data", wr_fifo_data, 32'd0);
    chk("mid_rst_address", {10'd0, address}, 32'd0);
    chk("mid_rst_dat_o", wbs_dat_o, 32'd0);
    end_cyc();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    chk("wr_sb_empty", 32'(wr_exp.size()), 32'd0);
    chk("rd_sb_empty", 32'(rd_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
